// File: rtl/mips_trace_capture.sv
// Trace observer for mips_top: captures {PC, ALU, dmem} per sampled cycle into a record FIFO,
// streams each record as three words over valid/ready, and freezes capture on a PC self-loop.
module mips_trace_capture #(
  parameter int DEPTH       = 8,
  parameter int HALT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_global,
  input  logic             capture_en,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      alu_in,
  input  logic [31:0]      dmem_in,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             overflow,
  output logic             halted,
  output logic [CNT_W-1:0] rec_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SCW = $clog2(HALT_CYCLES);
  localparam logic [AW:0]    DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0]    ONE_P   = (AW+1)'(1);
  localparam logic [SCW-1:0] SC_HALT = SCW'(HALT_CYCLES - 2);
  localparam logic [SCW-1:0] SC_MAX  = SCW'(HALT_CYCLES - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dmem;
  } rec_t;

  typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

  rec_t              mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q, count;
  logic [AW-1:0]     rd_idx, nxt_idx;
  state_t            state_q;
  logic [31:0]       out_data_q;
  logic              out_valid_q, out_last_q;
  logic              overflow_q, halted_q;
  logic [CNT_W-1:0]  rec_count_q, rec_count_d, drop_count_q, drop_count_d;
  logic              prev_vld_q;
  logic [31:0]       prev_pc_q;
  logic [SCW-1:0]    same_cnt_q;
  logic              empty, full, sample, pop, push, drop;
  rec_t              rec_in;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_P);
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign nxt_idx = rd_idx + AW'(1);
  assign rec_in  = '{pc: pc_in, alu: alu_in, dmem: dmem_in};

  // A full FIFO that is popping this edge has room for the incoming sample.
  assign sample = capture_en & ~halted_q;
  assign pop    = (state_q == W2) & out_ready;
  assign push   = sample & (~full | pop);
  assign drop   = sample & full & ~pop;

  assign rec_count_d  = (push && rec_count_q  != '1) ? rec_count_q  + 1'b1 : rec_count_q;
  assign drop_count_d = (drop && drop_count_q != '1) ? drop_count_q + 1'b1 : drop_count_q;

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign halted     = halted_q;
  assign rec_count  = rec_count_q;
  assign drop_count = drop_count_q;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge clock) begin
    if (reset_global) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      rec_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      rec_count_q  <= rec_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Halt detector: same_cnt counts repeats of prev_pc across sampled cycles only.
  always_ff @(posedge clock) begin
    if (reset_global) begin
      prev_vld_q <= 1'b0;
      prev_pc_q  <= '0;
      same_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else if (sample) begin
      if (!prev_vld_q) begin
        prev_vld_q <= 1'b1;
        prev_pc_q  <= pc_in;
        same_cnt_q <= '0;
      end else if (pc_in == prev_pc_q) begin
        if (same_cnt_q == SC_HALT) halted_q <= 1'b1;
        if (same_cnt_q != SC_MAX)  same_cnt_q <= same_cnt_q + 1'b1;
      end else begin
        prev_pc_q  <= pc_in;
        same_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_global) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          state_q     <= W0;
          out_data_q  <= mem_q[rd_idx].pc;
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
        end
        W0: if (out_ready) begin
          state_q    <= W1;
          out_data_q <= mem_q[rd_idx].alu;
        end
        W1: if (out_ready) begin
          state_q    <= W2;
          out_data_q <= mem_q[rd_idx].dmem;
          out_last_q <= 1'b1;
        end
        W2: if (out_ready) begin
          out_last_q <= 1'b0;
          // Next head is either already queued or being written on this very edge.
          if (count > ONE_P) begin
            state_q    <= W0;
            out_data_q <= mem_q[nxt_idx].pc;
          end else if (push) begin
            state_q    <= W0;
            out_data_q <= pc_in;
          end else begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_trace_capture.sv
// Directed bench for mips_trace_capture: a vector table for streaming/backpressure plus
// hand sequences for overflow, full-with-pop, mid-record reset and halt detection.
module tb_mips_trace_capture;

  logic        clock, reset_global, capture_en, out_ready;
  logic [31:0] pc_in, alu_in, dmem_in, out_data;
  logic        out_valid, out_last, overflow, halted;
  logic [15:0] rec_count, drop_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] dw[$];
  logic        dl[$];

  mips_trace_capture #(.DEPTH(8), .HALT_CYCLES(4), .CNT_W(16)) dut (
    .clock(clock), .reset_global(reset_global), .capture_en(capture_en),
    .pc_in(pc_in), .alu_in(alu_in), .dmem_in(dmem_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .overflow(overflow), .halted(halted), .rec_count(rec_count), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    logic        cap;
    logic [31:0] pc, alu, dmem;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_l;
  } vec_t;

  vec_t vt[15];

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_global = 1'b1;
    capture_en   = 1'b0;
    out_ready    = 1'b0;
    step();
    step();
    reset_global = 1'b0;
  endtask

  task automatic drain(input int n);
    dw.delete();
    dl.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 200 && dw.size() < n; c++) begin
      if (out_valid) begin
        dw.push_back(out_data);
        dl.push_back(out_last);
      end
      step();
    end
    chk("drain_words", dw.size(), n);
  endtask

  function automatic vec_t mk(logic cap, logic [31:0] pc, logic [31:0] alu, logic [31:0] dmem,
                              logic rdy, logic ev, logic [31:0] ed, logic el);
    vec_t v;
    v.cap = cap; v.pc = pc; v.alu = alu; v.dmem = dmem; v.rdy = rdy;
    v.exp_v = ev; v.exp_d = ed; v.exp_l = el;
    return v;
  endfunction

  initial begin
    logic [31:0] pcs [7];

    vt[0]  = mk(1, 32'h0040_0000, 32'h5, 32'hDEAD_BEEF, 1, 0, 32'h0, 0);
    vt[1]  = mk(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0040_0000, 0);
    vt[2]  = mk(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h5, 0);
    vt[3]  = mk(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'hDEAD_BEEF, 1);
    vt[4]  = mk(0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, 0);
    vt[5]  = mk(1, 32'h0040_0100, 32'h5, 32'h0000_CAFE, 1, 0, 32'h0, 0);
    vt[6]  = mk(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0040_0100, 0);
    vt[7]  = mk(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h5, 0);
    for (int i = 8; i < 13; i++) vt[i] = mk(0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h5, 0);
    vt[13] = mk(0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0000_CAFE, 1);
    vt[14] = mk(0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0, 0);

    pc_in = '0; alu_in = '0; dmem_in = '0;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rec", rec_count, 0);
    chk("rst_drop", drop_count, 0);

    // Single record and backpressure from the table.
    for (int i = 0; i < 15; i++) begin
      capture_en = vt[i].cap; pc_in = vt[i].pc; alu_in = vt[i].alu; dmem_in = vt[i].dmem;
      out_ready  = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].exp_v);
      chk($sformatf("vec%0d_last", i), out_last, vt[i].exp_l);
      if (vt[i].exp_v) chk($sformatf("vec%0d_data", i), out_data, vt[i].exp_d);
      if (i == 4) chk("single_rec_count", rec_count, 1);
    end
    capture_en = 1'b0;
    chk("table_rec", rec_count, 2);
    chk("table_overflow", overflow, 0);

    // Overflow: 10 distinct PCs into an 8-deep FIFO with the consumer stalled.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      capture_en = 1'b1; pc_in = 32'h1000 + 4 * i; alu_in = i; dmem_in = 32'hA000_0000 | i;
      step();
    end
    capture_en = 1'b0;
    chk("ovf_rec", rec_count, 8);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_flag", overflow, 1);
    drain(24);
    for (int k = 0; k < dw.size(); k++) begin
      case (k % 3)
        0: chk($sformatf("ovf_w%0d", k), dw[k], 32'h1000 + 4 * (k / 3));
        1: chk($sformatf("ovf_w%0d", k), dw[k], k / 3);
        default: chk($sformatf("ovf_w%0d", k), dw[k], 32'hA000_0000 | (k / 3));
      endcase
      chk($sformatf("ovf_l%0d", k), dl[k], (k % 3) == 2);
    end
    chk("ovf_idle", out_valid, 0);

    // Full FIFO with a W2 handshake on the same edge as a new sample.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      capture_en = 1'b1; pc_in = 32'h2000 + 4 * i; alu_in = 100 + i; dmem_in = 32'hB000_0000 | i;
      step();
    end
    capture_en = 1'b0;
    chk("fp_w0", out_data, 32'h2000);
    out_ready = 1'b1;
    step();
    chk("fp_w1", out_data, 100);
    step();
    chk("fp_w2_last", out_last, 1);
    capture_en = 1'b1; pc_in = 32'h3000; alu_in = 32'h33; dmem_in = 32'h3333;
    step();
    capture_en = 1'b0;
    chk("fp_overflow", overflow, 0);
    chk("fp_rec", rec_count, 9);
    chk("fp_drop", drop_count, 0);
    chk("fp_nobubble_v", out_valid, 1);
    chk("fp_nobubble_d", out_data, 32'h2004);
    drain(24);
    for (int j = 0; j < 8 && 3 * j + 2 < dw.size(); j++) begin
      chk($sformatf("fp_pc%0d", j), dw[3 * j], (j < 7) ? 32'h2004 + 4 * j : 32'h3000);
      if (j == 7) chk("fp_new_dmem", dw[3 * j + 2], 32'h3333);
    end

    // Reset asserted while the FSM sits in W1.
    capture_en = 1'b1; pc_in = 32'h5000; alu_in = 32'h55; dmem_in = 32'h5555;
    step();
    capture_en = 1'b0;
    step();
    step();
    chk("mid_w1_data", out_data, 32'h55);
    reset_global = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_rec", rec_count, 0);
    reset_global = 1'b0;
    step();
    chk("mid_rst_idle1", out_valid, 0);
    step();
    chk("mid_rst_idle2", out_valid, 0);

    // Halt on the 4th identical PC; the 7th sample must not be captured.
    pcs = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8};
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      capture_en = 1'b1; pc_in = pcs[i]; alu_in = 32'h70 + i; dmem_in = 32'h0;
      step();
      if (i == 4) chk("halt_before", halted, 0);
      if (i == 5) chk("halt_set", halted, 1);
    end
    capture_en = 1'b0;
    chk("halt_rec", rec_count, 6);
    chk("halt_drop", drop_count, 0);
    chk("halt_overflow", overflow, 0);
    drain(18);
    for (int j = 0; j < 6 && 3 * j + 1 < dw.size(); j++) begin
      chk($sformatf("halt_pc%0d", j), dw[3 * j], pcs[j]);
      chk($sformatf("halt_alu%0d", j), dw[3 * j + 1], 32'h70 + j);
    end
    step();
    chk("halt_sticky", halted, 1);
    chk("halt_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
